// File: rtl/spatz_vrf_banked.sv
// spatz_vrf_banked: banked vector register file with per-bank age-boosted arbitration.
//
// Addresses are {reg, bank, elem} with elem in the LSBs. Each bank has NrBankRdPorts read ports
// and a single write port. Requests that are denied age in a saturating counter. Once the
// counter reaches StallLimit the request is urgent. Urgent requests are granted ahead of
// non-urgent ones, and lower port indices win within each class.
//
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   waddr_i/wdata_i    per-write-port address, data, byte enables and request
//   wbe_i/we_i
//   wgnt_o             write grants (combinational)
//   raddr_i/re_i       per-read-port address and request
//   rgnt_o             read grants (combinational)
//   rdata_o/rvalid_o   read data and valid, registered, one cycle after grant
//
// Optional feature: define SPATZ_VRF_FWD_EN to forward a same-cycle granted write into a
// granted read of the same row. When it is defined, byte-enabled bytes come from wdata.
module spatz_vrf_banked #(
    parameter int unsigned NrReadPorts   = 5,
    parameter int unsigned NrWritePorts  = 3,
    parameter int unsigned NrBanks       = 4,
    parameter int unsigned NrBankRdPorts = 2,
    parameter int unsigned NrRegs        = 32,
    parameter int unsigned ElemPerBank   = 2,
    parameter int unsigned ElemWidth     = 64,
    parameter int unsigned StallLimit    = 3,
    localparam int unsigned AW = $clog2(NrRegs) + $clog2(NrBanks) + $clog2(ElemPerBank)
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [NrWritePorts-1:0][AW-1:0]         waddr_i,
    input  logic [NrWritePorts-1:0][ElemWidth-1:0]  wdata_i,
    input  logic [NrWritePorts-1:0][ElemWidth/8-1:0] wbe_i,
    input  logic [NrWritePorts-1:0]                 we_i,
    output logic [NrWritePorts-1:0]                 wgnt_o,
    input  logic [NrReadPorts-1:0][AW-1:0]          raddr_i,
    input  logic [NrReadPorts-1:0]                  re_i,
    output logic [NrReadPorts-1:0]                  rgnt_o,
    output logic [NrReadPorts-1:0][ElemWidth-1:0]   rdata_o,
    output logic [NrReadPorts-1:0]                  rvalid_o
);

    localparam int unsigned BW    = $clog2(NrBanks);
    localparam int unsigned EW    = $clog2(ElemPerBank);
    localparam int unsigned RW    = AW - BW;
    localparam int unsigned Depth = 2 ** AW;
    localparam int unsigned NB    = ElemWidth / 8;
    localparam int unsigned SW    = $clog2(StallLimit + 1);
    localparam logic [SW-1:0] StallMax = SW'(StallLimit);

    function automatic logic [BW-1:0] bank_of(input logic [AW-1:0] a);
        return BW'(a >> EW);
    endfunction

    // Row within a bank is {reg, elem}: drop the bank field from the middle.
    function automatic logic [RW-1:0] row_of(input logic [AW-1:0] a);
        logic [AW-1:0] hi;
        logic [AW-1:0] lo;
        hi = (a >> (EW + BW)) << EW;
        lo = a & AW'(ElemPerBank - 1);
        return RW'(hi | lo);
    endfunction

    function automatic logic [AW-1:0] idx_of(input logic [AW-1:0] a);
        return {bank_of(a), row_of(a)};
    endfunction

    logic [ElemWidth-1:0] mem_q [Depth];

    logic [NrReadPorts-1:0]                 rgnt;
    logic [NrWritePorts-1:0]                wgnt;
    logic [NrReadPorts-1:0][SW-1:0]         rstall_q, rstall_d;
    logic [NrWritePorts-1:0][SW-1:0]        wstall_q, wstall_d;
    logic [NrReadPorts-1:0][ElemWidth-1:0]  rdata_q, rdata_d;
    logic [NrReadPorts-1:0]                 rvalid_q, rvalid_d;

    // Read arbitration: pass 0 serves urgent ports, pass 1 the rest, up to NrBankRdPorts per bank.
    always_comb begin
        int unsigned cnt;
        cnt  = 0;
        rgnt = '0;
        if (!rst_i) begin
            for (int b = 0; b < NrBanks; b++) begin
                cnt = 0;
                for (int pass = 0; pass < 2; pass++) begin
                    for (int p = 0; p < NrReadPorts; p++) begin
                        if (re_i[p] && (bank_of(raddr_i[p]) == BW'(b)) &&
                            ((rstall_q[p] == StallMax) == (pass == 0)) &&
                            (cnt < NrBankRdPorts)) begin
                            rgnt[p] = 1'b1;
                            cnt++;
                        end
                    end
                end
            end
        end
    end

    // Write arbitration: same ordering, single grant per bank.
    always_comb begin
        logic taken;
        taken = 1'b0;
        wgnt  = '0;
        if (!rst_i) begin
            for (int b = 0; b < NrBanks; b++) begin
                taken = 1'b0;
                for (int pass = 0; pass < 2; pass++) begin
                    for (int w = 0; w < NrWritePorts; w++) begin
                        if (we_i[w] && (bank_of(waddr_i[w]) == BW'(b)) &&
                            ((wstall_q[w] == StallMax) == (pass == 0)) && !taken) begin
                            wgnt[w] = 1'b1;
                            taken   = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Age counters: cleared on grant or idle, saturate at StallLimit while denied.
    always_comb begin
        rstall_d = rstall_q;
        wstall_d = wstall_q;
        for (int p = 0; p < NrReadPorts; p++) begin
            if (!re_i[p] || rgnt[p]) begin
                rstall_d[p] = '0;
            end else if (rstall_q[p] != StallMax) begin
                rstall_d[p] = rstall_q[p] + 1'b1;
            end
        end
        for (int w = 0; w < NrWritePorts; w++) begin
            if (!we_i[w] || wgnt[w]) begin
                wstall_d[w] = '0;
            end else if (wstall_q[w] != StallMax) begin
                wstall_d[w] = wstall_q[w] + 1'b1;
            end
        end
    end

    // Read data path: sample the row on grant, otherwise hold the last delivered word.
    always_comb begin
        logic [ElemWidth-1:0] word;
        word     = '0;
        rdata_d  = rdata_q;
        rvalid_d = rgnt;
        if (rst_i) begin
            rdata_d  = '0;
            rvalid_d = '0;
        end else begin
            for (int p = 0; p < NrReadPorts; p++) begin
                if (rgnt[p]) begin
                    word = mem_q[idx_of(raddr_i[p])];
`ifdef SPATZ_VRF_FWD_EN
                    for (int w = 0; w < NrWritePorts; w++) begin
                        if (wgnt[w] && (idx_of(waddr_i[w]) == idx_of(raddr_i[p]))) begin
                            for (int k = 0; k < NB; k++) begin
                                if (wbe_i[w][k]) begin
                                    word[8*k +: 8] = wdata_i[w][8*k +: 8];
                                end
                            end
                        end
                    end
`else
                    // Reads see pre-write storage; no bypass path.
`endif
                    rdata_d[p] = word;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rstall_q <= '0;
            wstall_q <= '0;
            rdata_q  <= '0;
            rvalid_q <= '0;
        end else begin
            rstall_q <= rstall_d;
            wstall_q <= wstall_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Storage is not reset. Grants are already suppressed under reset, so no write lands then.
    always_ff @(posedge clk_i) begin
        for (int w = 0; w < NrWritePorts; w++) begin
            for (int k = 0; k < NB; k++) begin
                if (wgnt[w] && wbe_i[w][k]) begin
                    mem_q[idx_of(waddr_i[w])][8*k +: 8] <= wdata_i[w][8*k +: 8];
                end
            end
        end
    end

    assign rgnt_o   = rgnt;
    assign wgnt_o   = wgnt;
    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;

endmodule

// File: tb/tb_spatz_vrf_banked.sv
// Directed bench for spatz_vrf_banked with default parameters (AW = 8, address {reg, bank, elem}).
module tb_spatz_vrf_banked;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [2:0][7:0]   waddr;
    logic [2:0][63:0]  wdata;
    logic [2:0][7:0]   wbe;
    logic [2:0]        we;
    logic [2:0]        wgnt;
    logic [4:0][7:0]   raddr;
    logic [4:0]        re;
    logic [4:0]        rgnt;
    logic [4:0][63:0]  rdata;
    logic [4:0]        rvalid;

    spatz_vrf_banked dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .waddr_i  (waddr),
        .wdata_i  (wdata),
        .wbe_i    (wbe),
        .we_i     (we),
        .wgnt_o   (wgnt),
        .raddr_i  (raddr),
        .re_i     (re),
        .rgnt_o   (rgnt),
        .rdata_o  (rdata),
        .rvalid_o (rvalid)
    );

    typedef struct {
        logic [2:0]       we;
        logic [2:0][7:0]  waddr;
        logic [2:0][63:0] wdata;
        logic [2:0][7:0]  wbe;
        logic [4:0]       re;
        logic [4:0][7:0]  raddr;
        logic [2:0]       exp_wgnt;
        logic [4:0]       exp_rgnt;
        logic [4:0]       exp_rvalid;
        logic             chk_rd;
        logic [63:0]      exp_rdata0;
    } vec_t;

`ifdef SPATZ_VRF_FWD_EN
    localparam logic [63:0] RwExp = 64'hB;
`else
    localparam logic [63:0] RwExp = 64'hA;
`endif

    localparam logic [63:0] D0 = 64'h1122334455667788;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];
    vec_t v;
    logic [4:0] cont_exp [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        we    = '0;
        waddr = '0;
        wdata = '0;
        wbe   = '0;
        re    = '0;
        raddr = '0;
    endtask

    function automatic vec_t blank();
        vec_t b;
        b.we = '0; b.waddr = '0; b.wdata = '0; b.wbe = '0;
        b.re = '0; b.raddr = '0;
        b.exp_wgnt = '0; b.exp_rgnt = '0; b.exp_rvalid = '0;
        b.chk_rd = 1'b0; b.exp_rdata0 = '0;
        return b;
    endfunction

    initial begin
        // Basic write then read.
        v = blank(); v.we = 3'b001; v.waddr[0] = 8'h00; v.wdata[0] = D0; v.wbe[0] = 8'hFF;
        v.exp_wgnt = 3'b001; vecs.push_back(v);
        v = blank(); v.re = 5'b00001; v.raddr[0] = 8'h00; v.exp_rgnt = 5'b00001; vecs.push_back(v);
        v = blank(); v.exp_rvalid = 5'b00001; v.chk_rd = 1'b1; v.exp_rdata0 = D0; vecs.push_back(v);
        // Byte enables; rdata holds while rvalid is low.
        v = blank(); v.we = 3'b001; v.waddr[0] = 8'h04; v.wdata[0] = '1; v.wbe[0] = 8'hFF;
        v.exp_wgnt = 3'b001; v.chk_rd = 1'b1; v.exp_rdata0 = D0; vecs.push_back(v);
        v = blank(); v.we = 3'b001; v.waddr[0] = 8'h04; v.wdata[0] = '0; v.wbe[0] = 8'h0F;
        v.exp_wgnt = 3'b001; vecs.push_back(v);
        v = blank(); v.re = 5'b00001; v.raddr[0] = 8'h04; v.exp_rgnt = 5'b00001; vecs.push_back(v);
        v = blank(); v.exp_rvalid = 5'b00001; v.chk_rd = 1'b1;
        v.exp_rdata0 = 64'hFFFFFFFF00000000; vecs.push_back(v);
        // Write contention: ports 0 and 2 on bank 3, port 1 on bank 1.
        v = blank(); v.we = 3'b111; v.waddr[0] = 8'h06; v.waddr[1] = 8'h02; v.waddr[2] = 8'h0E;
        v.wbe = '1; v.exp_wgnt = 3'b011; vecs.push_back(v);
        v = blank(); v.we = 3'b100; v.waddr[2] = 8'h0E; v.wbe[2] = 8'hFF;
        v.exp_wgnt = 3'b100; vecs.push_back(v);
        // Granted write with no byte enables is a no-op.
        v = blank(); v.we = 3'b001; v.waddr[0] = 8'h00; v.wdata[0] = '0; v.wbe[0] = 8'h00;
        v.exp_wgnt = 3'b001; vecs.push_back(v);
        v = blank(); v.re = 5'b00001; v.raddr[0] = 8'h00; v.exp_rgnt = 5'b00001; vecs.push_back(v);
        v = blank(); v.exp_rvalid = 5'b00001; v.chk_rd = 1'b1; v.exp_rdata0 = D0; vecs.push_back(v);
        // Same-cycle write and read of one row.
        v = blank(); v.we = 3'b001; v.waddr[0] = 8'h08; v.wdata[0] = 64'hA; v.wbe[0] = 8'hFF;
        v.exp_wgnt = 3'b001; vecs.push_back(v);
        v = blank(); v.we = 3'b001; v.waddr[0] = 8'h08; v.wdata[0] = 64'hB; v.wbe[0] = 8'hFF;
        v.re = 5'b00001; v.raddr[0] = 8'h08; v.exp_wgnt = 3'b001; v.exp_rgnt = 5'b00001;
        vecs.push_back(v);
        v = blank(); v.exp_rvalid = 5'b00001; v.chk_rd = 1'b1; v.exp_rdata0 = RwExp;
        vecs.push_back(v);
        // Two ports read the same row.
        v = blank(); v.re = 5'b00011; v.raddr[0] = 8'h08; v.raddr[1] = 8'h08;
        v.exp_rgnt = 5'b00011; vecs.push_back(v);
        v = blank(); v.exp_rvalid = 5'b00011; v.chk_rd = 1'b1; v.exp_rdata0 = 64'hB;
        vecs.push_back(v);

        cont_exp[0] = 5'b00011; cont_exp[1] = 5'b00011; cont_exp[2] = 5'b00011;
        cont_exp[3] = 5'b00101; cont_exp[4] = 5'b00011;

        // Reset with requests asserted: no grants, registered outputs cleared.
        rst = 1'b1;
        set_idle();
        we = 3'b111; waddr[1] = 8'h02; waddr[2] = 8'h04; wbe = '1;
        re = 5'b11111;
        tick();
        tick();
        chk("reset_wgnt", 64'(wgnt), 64'h0);
        chk("reset_rgnt", 64'(rgnt), 64'h0);
        chk("reset_rvalid", 64'(rvalid), 64'h0);
        chk("reset_rdata0", rdata[0], 64'h0);
        rst = 1'b0;
        set_idle();

        foreach (vecs[i]) begin
            we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata; wbe = vecs[i].wbe;
            re = vecs[i].re; raddr = vecs[i].raddr;
            #1;
            chk($sformatf("vec%0d_wgnt", i), 64'(wgnt), 64'(vecs[i].exp_wgnt));
            chk($sformatf("vec%0d_rgnt", i), 64'(rgnt), 64'(vecs[i].exp_rgnt));
            chk($sformatf("vec%0d_rvalid", i), 64'(rvalid), 64'(vecs[i].exp_rvalid));
            if (vecs[i].chk_rd) chk($sformatf("vec%0d_rdata0", i), rdata[0], vecs[i].exp_rdata0);
            tick();
        end
        set_idle();
        tick();

        // Read contention on bank 1: port 2 becomes urgent after three denials.
        re = 5'b00111; raddr[0] = 8'h02; raddr[1] = 8'h0A; raddr[2] = 8'h12;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("cont_c%0d_rgnt", c + 1), 64'(rgnt), 64'(cont_exp[c]));
            tick();
        end
        set_idle();
        tick();

        // Build up urgency again, then reset the cycle after a read grant.
        re = 5'b00111; raddr[0] = 8'h02; raddr[1] = 8'h0A; raddr[2] = 8'h12;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("pre_rst_c%0d_rgnt", c + 1), 64'(rgnt), 64'(cont_exp[c]));
            tick();
        end
        rst = 1'b1;
        we = 3'b001; waddr[0] = 8'h08; wdata[0] = 64'hC; wbe[0] = 8'hFF;
        #1;
        chk("rst_cycle_rgnt", 64'(rgnt), 64'h0);
        chk("rst_cycle_wgnt", 64'(wgnt), 64'h0);
        chk("rst_cycle_rvalid", 64'(rvalid), 64'h03);
        tick();
        rst = 1'b0;
        we = '0;
        #1;
        chk("post_rst_rvalid", 64'(rvalid), 64'h0);
        chk("post_rst_rdata0", rdata[0], 64'h0);
        chk("post_rst_rgnt", 64'(rgnt), 64'h03);
        tick();
        set_idle();
        tick();

        // The write issued during reset must not have landed.
        re = 5'b00001; raddr[0] = 8'h08;
        #1;
        chk("rst_write_rgnt", 64'(rgnt), 64'h01);
        tick();
        set_idle();
        #1;
        chk("rst_write_rvalid", 64'(rvalid), 64'h01);
        chk("rst_write_rdata0", rdata[0], 64'hB);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
